// File: rtl/ttt_pkg.sv
// Shared definitions for the tic-tac-toe core: cell and winner codes, FSM
// state encodings, win-line table and board helper functions.
package ttt_pkg;

   localparam logic [1:0] CELL_EMPTY = 2'b00;
   localparam logic [1:0] CELL_X     = 2'b01;
   localparam logic [1:0] CELL_O     = 2'b10;

   localparam logic [1:0] WIN_NONE   = 2'b00;
   localparam logic [1:0] WIN_X      = 2'b01;
   localparam logic [1:0] WIN_O      = 2'b10;
   localparam logic [1:0] WIN_TIE    = 2'b11;

   localparam int unsigned NUM_CELLS = 9;
   localparam int unsigned NUM_LINES = 8;
   localparam logic [3:0]  NO_CELL   = 4'hF;

   typedef logic [2:0] state_t;

   localparam state_t P_WAIT   = 3'd0;
   localparam state_t P_CHECK  = 3'd1;
   localparam state_t AI_START = 3'd2;
   localparam state_t AI_WAIT  = 3'd3;
   localparam state_t AI_CHECK = 3'd4;
   localparam state_t OVER     = 3'd5;

   // Rows, columns, then the two diagonals.
   localparam logic [3:0] WIN_LINES [NUM_LINES][3] = '{
      '{4'd0, 4'd1, 4'd2},
      '{4'd3, 4'd4, 4'd5},
      '{4'd6, 4'd7, 4'd8},
      '{4'd0, 4'd3, 4'd6},
      '{4'd1, 4'd4, 4'd7},
      '{4'd2, 4'd5, 4'd8},
      '{4'd0, 4'd4, 4'd8},
      '{4'd2, 4'd4, 4'd6}
   };

   // Read one cell; indices beyond the board read as 11 so they never
   // look empty.
   function automatic logic [1:0] cell_of(input logic [17:0] board, input logic [3:0] idx);
      logic [1:0] code;
      code = 2'b11;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (idx == 4'(i)) code = board[2*i +: 2];
      end
      return code;
   endfunction

   // Write one cell; indices beyond the board leave it untouched.
   function automatic logic [17:0] set_cell(input logic [17:0] board, input logic [3:0] idx,
                                            input logic [1:0] code);
      logic [17:0] nb;
      nb = board;
      for (int i = 0; i < NUM_CELLS; i++) begin
         if (idx == 4'(i)) nb[2*i +: 2] = code;
      end
      return nb;
   endfunction

   // 1 when every cell of at least one line holds the given code.
   function automatic logic line_owner(input logic [17:0] board, input logic [1:0] code);
      logic hit;
      logic full;
      hit = 1'b0;
      for (int l = 0; l < NUM_LINES; l++) begin
         full = 1'b1;
         for (int k = 0; k < 3; k++) begin
            if (cell_of(board, WIN_LINES[l][k]) != code) full = 1'b0;
         end
         if (full) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/ttt_core_ai.sv
// Hardware opponent: captures the board on start, picks a cell one cycle
// later and presents it with a single-cycle done pulse.
module ai_agent
   import ttt_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [17:0] cell_position,
   output logic [3:0]  ai_tick,
   output logic        done
);

   logic        vld_p0_q;
   logic [17:0] board_p0_q;
   logic        vld_p1_q;
   logic [3:0]  tick_p1_q;
   logic [3:0]  tick_q;
   logic        done_q;

   // Centre first, otherwise the highest-index empty cell. A full board
   // yields NO_CELL, which the top treats as an invalid reply.
   function automatic logic [3:0] pick_cell(input logic [17:0] board);
      logic [3:0] sel;
      sel = NO_CELL;
      if (cell_of(board, 4'd4) == CELL_EMPTY) begin
         sel = 4'd4;
      end else begin
         for (int i = 0; i < NUM_CELLS; i++) begin
            if (cell_of(board, 4'(i)) == CELL_EMPTY) sel = 4'(i);
         end
      end
      return sel;
   endfunction

   // Control path: valid bits and done pulse, cleared by reset so a
   // request in flight is dropped.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p0_q <= 1'b0;
         vld_p1_q <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         vld_p0_q <= start;
         vld_p1_q <= vld_p0_q;
         done_q   <= vld_p1_q;
      end
   end

   // Data path: stage p0 captures the board, stage p1 selects, the output
   // register holds the choice until the next request completes.
   always_ff @(posedge clk) begin
      if (start) board_p0_q <= cell_position;
      // stage p0 -> p1
      if (vld_p0_q) tick_p1_q <= pick_cell(board_p0_q);
      // stage p1 -> output
      if (vld_p1_q) tick_q <= tick_p1_q;
   end

   assign ai_tick = tick_q;
   assign done    = done_q;

endmodule

// File: rtl/ttt_core.sv
// Tic-tac-toe game core: player move entry, AI reply sequencing, win and
// tie detection, and the board/status registers seen by the UI.
module ttt_core
   import ttt_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic [3:0]  p_tick,
   input  logic        p_confirm,
   output logic [17:0] cell_position,
   output logic [1:0]  winner,
   output logic        player_turn,
   output logic [3:0]  move_cnt
);

   state_t      state_q,    state_d;
   logic [17:0] board_q,    board_d;
   logic [1:0]  winner_q,   winner_d;
   logic        turn_q,     turn_d;
   logic [3:0]  cnt_q,      cnt_d;
   logic        ai_start_q, ai_start_d;
   logic        p_confirm_q;
   logic        p_rise;
   logic [3:0]  ai_tick;
   logic        ai_done;

   assign p_rise = p_confirm & ~p_confirm_q;

   ai_agent u_ai (
      .clk           (clk),
      .rst           (rst),
      .start         (ai_start_q),
      .cell_position (board_q),
      .ai_tick       (ai_tick),
      .done          (ai_done)
   );

   // Next-state logic for the game FSM and the board/status registers.
   always_comb begin
      state_d    = state_q;
      board_d    = board_q;
      winner_d   = winner_q;
      turn_d     = turn_q;
      cnt_d      = cnt_q;
      ai_start_d = 1'b0;
      case (state_q)
         P_WAIT: begin
            if (p_rise && (p_tick <= 4'd8) && (cell_of(board_q, p_tick) == CELL_EMPTY)) begin
               board_d = set_cell(board_q, p_tick, CELL_X);
               cnt_d   = cnt_q + 4'd1;
               turn_d  = 1'b0;
               state_d = P_CHECK;
            end
         end
         P_CHECK: begin
            if (line_owner(board_q, CELL_X)) begin
               winner_d = WIN_X;
               state_d  = OVER;
            end else if (cnt_q == 4'd9) begin
               winner_d = WIN_TIE;
               state_d  = OVER;
            end else begin
               state_d = AI_START;
            end
         end
         AI_START: begin
            ai_start_d = 1'b1;
            state_d    = AI_WAIT;
         end
         AI_WAIT: begin
            if (ai_done) begin
               if ((ai_tick <= 4'd8) && (cell_of(board_q, ai_tick) == CELL_EMPTY)) begin
                  board_d = set_cell(board_q, ai_tick, CELL_O);
                  cnt_d   = cnt_q + 4'd1;
                  state_d = AI_CHECK;
               end else begin
                  // Invalid reply: hand the move back to the player unchanged.
                  turn_d  = 1'b1;
                  state_d = P_WAIT;
               end
            end
         end
         AI_CHECK: begin
            if (line_owner(board_q, CELL_O)) begin
               winner_d = WIN_O;
               state_d  = OVER;
            end else if (cnt_q == 4'd9) begin
               winner_d = WIN_TIE;
               state_d  = OVER;
            end else begin
               turn_d  = 1'b1;
               state_d = P_WAIT;
            end
         end
         OVER: begin
            // The restarting edge is consumed here and never places a move.
            if (p_rise) begin
               board_d  = '0;
               cnt_d    = 4'd0;
               winner_d = WIN_NONE;
               turn_d   = 1'b1;
               state_d  = P_WAIT;
            end
         end
         default: begin
            state_d = P_WAIT;
         end
      endcase
   end

   // State, board and confirm-history registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= P_WAIT;
         board_q     <= '0;
         winner_q    <= WIN_NONE;
         turn_q      <= 1'b1;
         cnt_q       <= 4'd0;
         ai_start_q  <= 1'b0;
         p_confirm_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         board_q     <= board_d;
         winner_q    <= winner_d;
         turn_q      <= turn_d;
         cnt_q       <= cnt_d;
         ai_start_q  <= ai_start_d;
         p_confirm_q <= p_confirm;
      end
   end

   assign cell_position = board_q;
   assign winner        = winner_q;
   assign player_turn   = turn_q;
   assign move_cnt      = cnt_q;

endmodule

// File: tb/tb_ttt_core.sv
// Self-checking bench for ttt_core: table-driven games plus directed
// sequences for restart, illegal moves and mid-game reset.
module tb_ttt_core;

   logic        clk;
   logic        rst;
   logic [3:0]  p_tick;
   logic        p_confirm;
   logic [17:0] cell_position;
   logic [1:0]  winner;
   logic        player_turn;
   logic [3:0]  move_cnt;

   int total;
   int bad;
   logic [17:0] model_board;

   typedef struct {
      int tick;     // player cell
      int ai_cell;  // expected AI reply, 15 = no reply
      int cnt;      // expected move_cnt
      int turn;     // expected player_turn
      int win;      // expected winner
   } vec_t;

   vec_t game1 [3];
   vec_t game2 [5];

   ttt_core dut (
      .clk           (clk),
      .rst           (rst),
      .p_tick        (p_tick),
      .p_confirm     (p_confirm),
      .cell_position (cell_position),
      .winner        (winner),
      .player_turn   (player_turn),
      .move_cnt      (move_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #400000;
      $display("FAIL watchdog: got timeout required finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [17:0] put(input logic [17:0] b, input int idx, input logic [1:0] c);
      logic [17:0] nb;
      nb = b;
      nb[idx*2 +: 2] = c;
      return nb;
   endfunction

   task automatic check(input string name, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d (0x%0h) required %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic do_reset();
      @(posedge clk);
      #1 rst = 1'b1;
      p_confirm = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      model_board = '0;
   endtask

   // Single-cycle confirm pulse; returns just after the edge E0 that sees it.
   task automatic confirm(input int t);
      @(posedge clk);
      #1 p_tick = 4'(t);
      p_confirm = 1'b1;
      @(posedge clk);
      #1 p_confirm = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string tag);
      confirm(v.tick);
      repeat (28) @(posedge clk);
      @(negedge clk);
      model_board = put(model_board, v.tick, 2'b01);
      if (v.ai_cell < 9) model_board = put(model_board, v.ai_cell, 2'b10);
      check({tag, "_board"}, int'(cell_position), int'(model_board));
      check({tag, "_cnt"},   int'(move_cnt),      v.cnt);
      check({tag, "_turn"},  int'(player_turn),   v.turn);
      check({tag, "_win"},   int'(winner),        v.win);
   endtask

   initial begin
      total = 0;
      bad   = 0;
      rst = 1'b0;
      p_tick = 4'd0;
      p_confirm = 1'b0;
      model_board = '0;

      // Game 1: player takes the top row; AI answers centre then cell 8.
      game1[0] = '{tick: 0, ai_cell: 4,  cnt: 2, turn: 1, win: 0};
      game1[1] = '{tick: 1, ai_cell: 8,  cnt: 4, turn: 1, win: 0};
      game1[2] = '{tick: 2, ai_cell: 15, cnt: 5, turn: 0, win: 1};
      // Game 2: replies follow the centre-then-highest-empty policy
      // (8, 6, 5, 1); nobody completes a line and the 9th move ties.
      game2[0] = '{tick: 4, ai_cell: 8,  cnt: 2, turn: 1, win: 0};
      game2[1] = '{tick: 7, ai_cell: 6,  cnt: 4, turn: 1, win: 0};
      game2[2] = '{tick: 2, ai_cell: 5,  cnt: 6, turn: 1, win: 0};
      game2[3] = '{tick: 3, ai_cell: 1,  cnt: 8, turn: 1, win: 0};
      game2[4] = '{tick: 0, ai_cell: 15, cnt: 9, turn: 0, win: 3};

      // Reset state
      do_reset();
      @(negedge clk);
      check("rst_board", int'(cell_position), 0);
      check("rst_win",   int'(winner),        0);
      check("rst_turn",  int'(player_turn),   1);
      check("rst_cnt",   int'(move_cnt),      0);

      // Test 1: player wins
      for (int i = 0; i < 3; i++) run_vec(game1[i], $sformatf("g1m%0d", i));

      // Test 2: held confirm in OVER restarts once and places nothing
      @(posedge clk);
      #1 p_tick = 4'd2;
      p_confirm = 1'b1;
      repeat (3) @(posedge clk);
      #1 p_confirm = 1'b0;
      @(negedge clk);
      check("restart_board", int'(cell_position), 0);
      check("restart_cnt",   int'(move_cnt),      0);
      check("restart_win",   int'(winner),        0);
      check("restart_turn",  int'(player_turn),   1);
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("restart_nomove_board", int'(cell_position), 0);
      check("restart_nomove_cnt",   int'(move_cnt),      0);
      model_board = '0;

      // Test 3: player 0, AI reply lands within 8 cycles of E0
      confirm(0);
      @(negedge clk);
      check("t3_e0_cell0", int'(cell_position[1:0]), 1);
      check("t3_e0_turn",  int'(player_turn),        0);
      check("t3_e0_cnt",   int'(move_cnt),           1);
      repeat (7) @(posedge clk);
      @(negedge clk);
      check("t3_ai_cell4", int'(cell_position[9:8]), 2);
      check("t3_cnt",      int'(move_cnt),           2);
      check("t3_turn",     int'(player_turn),        1);
      model_board = put(put(18'd0, 0, 2'b01), 4, 2'b10);

      // Test 4: occupied cell and out-of-range index are ignored
      confirm(0);
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("t4_occ_board", int'(cell_position), int'(model_board));
      check("t4_occ_cnt",   int'(move_cnt),      2);
      check("t4_occ_turn",  int'(player_turn),   1);
      confirm(9);
      repeat (15) @(posedge clk);
      @(negedge clk);
      check("t4_oor_board", int'(cell_position), int'(model_board));
      check("t4_oor_cnt",   int'(move_cnt),      2);
      check("t4_oor_turn",  int'(player_turn),   1);

      // Test 5: full board tie
      do_reset();
      for (int i = 0; i < 5; i++) run_vec(game2[i], $sformatf("g2m%0d", i));

      // Test 6: reset while the AI request is in flight
      do_reset();
      confirm(0);
      repeat (3) @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("t6_board", int'(cell_position), 0);
      check("t6_win",   int'(winner),        0);
      check("t6_turn",  int'(player_turn),   1);
      check("t6_cnt",   int'(move_cnt),      0);
      repeat (10) @(posedge clk);
      @(negedge clk);
      check("t6_late_board", int'(cell_position), 0);
      check("t6_late_cnt",   int'(move_cnt),      0);
      check("t6_late_turn",  int'(player_turn),   1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
